mlaccel_qpi_phy: RTL and testbench
==================================

// Module: mlaccel_qpi_phy
// PURPOSE
//  QPI pad-side front end of mlaccel_top, sitting between the qpi_* pins and the command/memory engine.
//  - Synchronises qpi_csb/qpi_clk/qpi_io into the clock domain.
//  - Deserialises the DDR nibble stream into bytes and frames transactions.
//  - Serialises response bytes back onto qpi_io after a turnaround.
// PARAMETERS
//  SYNC_STAGES    2  synchroniser depth on csb/clk/io inputs (>=2)
//  DUMMY_CYCLES   1  byte-times of bus turnaround after tx_mode is first seen (0..3)
//  UNDERFLOW_BYTE 8'hFF  byte driven when the host clocks a read with no tx_valid
// PORTS
//  clock         in   1  system clock
//  reset         in   1  asynchronous, active-high reset
//  qpi_csb       in   1  chip select, active low
//  qpi_clk       in   1  host serial clock (idle high)
//  qpi_io_di     in   4  io pins input value
//  qpi_io_do     out  4  io pins output value
//  qpi_io_oe     out  1  io pins output enable
//  rx_start      out  1  1-cycle pulse: csb fall seen
//  rx_stop       out  1  1-cycle pulse: csb rise seen
//  rx_valid      out  1  1-cycle pulse: rx_data holds a complete byte (no backpressure)
//  rx_first      out  1  qualifies rx_valid: first byte of frame (command)
//  rx_data       out  8  received byte
//  tx_mode       in   1  core requests read direction for rest of frame
//  tx_valid      in   1  tx_data holds next response byte
//  tx_data       in   8  response byte
//  tx_ack        out  1  1-cycle pulse: tx_data consumed
//  err           out  1  sticky error for current frame
// BEHAVIOUR
//  - Reset: all outputs 0 (qpi_io_do=0, qpi_io_oe=0). Synchronisers load idle values: csb=1, clk=1.
//  - Edge detect on the synchronised clk, only while csb_s=0. io is synchronised with the same depth
//    as clk, so the sampled nibble is aligned with the detected edge.
//  - Host timing requirement: half-period >= SYNC_STAGES+2 clock cycles.
//  - FSM IDLE -> RX (csb fall, rx_start, nibble phase := HI, err := 0).
//    - RX: fall edge captures io as byte[7:4]; rise edge captures byte[3:0].
//      rx_valid pulses 1 cycle after the rise edge is detected; rx_first=1 only on the frame's first byte.
//    - RX -> TURN: on a fall edge with tx_mode=1 (that nibble is not captured).
//    - TURN: counts DUMMY_CYCLES fall/rise pairs with oe=0; no rx_valid.
//      On the last rise of TURN, tx_data is loaded and oe=1 with do=tx_data[7:4] (look-ahead).
//      DUMMY_CYCLES=0 performs this load on the entering fall edge.
//    - TX: on a fall edge, do := byte[3:0]. On a rise edge, tx_ack pulses, byte := tx_valid ? tx_data :
//      UNDERFLOW_BYTE, do := byte[7:4]. An underflow sets err.
//  - Any state -> IDLE on csb rise: rx_stop pulse; oe=0 the same cycle.
//    A partial byte (HI nibble held) is discarded and sets err.
//  - tx_mode dropping mid-frame is ignored; direction returns to RX only through IDLE.
//  - Simultaneous csb rise and clk edge: the csb rise wins and the edge is ignored.
//  - Reset mid-frame: everything clears and the block stays IDLE until csb_s is seen high, then low again
//    (no rx_start for the truncated frame).
//  - err is cleared at rx_start and stays readable after rx_stop until the next frame.
// CONFIGURATION
//  MLACCEL_QPI_STATS_EN defined:
//    - adds output stat_bytes[15:0]: count of rx_valid plus tx_ack pulses in the current frame.
//    - cleared at rx_start, saturates at 16'hFFFF, held after rx_stop.
//  MLACCEL_QPI_STATS_EN undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  1 Frame with bytes 21,01,00,08,00 -> rx_start; 5 rx_valid with data 21,01,00,08,00; rx_first only on
//    21; rx_stop; err=0.
//  2 Cmd 23, bytes 00,00,0A; core raises tx_mode and supplies 5A,00; host runs 1 dummy pair then 2 reads
//    -> io idle during dummy; host reads 5A then 00; tx_ack x2; oe low within 1 cycle of csb rise.
//  3 Read phase with tx_valid=0 -> host reads FF, err=1, tx_ack still pulses.
//  4 csb rises after only the high nibble of byte 2 -> byte 2 not delivered, rx_stop, err=1;
//    next frame -> err=0 at rx_start.
//  5 reset pulsed mid-frame at byte 3 -> outputs 0, no rx_valid or rx_start until csb goes high then low;
//    the following frame is received correctly.
//  6 With MLACCEL_QPI_STATS_EN, 3 rx bytes + 4 tx bytes -> stat_bytes=7 after rx_stop; 0 after next rx_start.

Source files
------------

// File: rtl/mlaccel_qpi_phy_if.sv
// rtl/mlaccel_qpi_phy_if.sv - QPI pin and core-side byte stream bundle for mlaccel_qpi_phy
interface mlaccel_qpi_phy_if;
    logic       qpi_csb;
    logic       qpi_clk;
    logic [3:0] qpi_io_di;
    logic [3:0] qpi_io_do;
    logic       qpi_io_oe;
    logic       rx_start;
    logic       rx_stop;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] rx_data;
    logic       tx_mode;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       err;
`ifdef MLACCEL_QPI_STATS_EN
    logic [15:0] stat_bytes;
`endif

    // master: host pins plus core response side; slave: the PHY itself
    modport master (
        output qpi_csb, qpi_clk, qpi_io_di, tx_mode, tx_valid, tx_data,
        input  qpi_io_do, qpi_io_oe, rx_start, rx_stop, rx_valid, rx_first, rx_data, tx_ack, err
`ifdef MLACCEL_QPI_STATS_EN
        , input stat_bytes
`endif
    );

    modport slave (
        input  qpi_csb, qpi_clk, qpi_io_di, tx_mode, tx_valid, tx_data,
        output qpi_io_do, qpi_io_oe, rx_start, rx_stop, rx_valid, rx_first, rx_data, tx_ack, err
`ifdef MLACCEL_QPI_STATS_EN
        , output stat_bytes
`endif
    );
endinterface

// File: rtl/mlaccel_qpi_phy.sv
// rtl/mlaccel_qpi_phy.sv - QPI pad front end: sync, DDR nibble deserialise/serialise, framing (option: MLACCEL_QPI_STATS_EN)
module mlaccel_qpi_phy #(
    parameter int          SYNC_STAGES    = 2,
    parameter int          DUMMY_CYCLES   = 1,
    parameter logic [7:0]  UNDERFLOW_BYTE = 8'hFF
) (
    input  logic               clock,
    input  logic               reset,
    mlaccel_qpi_phy_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RX, TURN, TX} state_t;

    localparam int LAST_DUMMY = (DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0;

    logic [SYNC_STAGES-1:0]      csb_sync, clk_sync, vld_sync;
    logic [SYNC_STAGES-1:0][3:0] io_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csb_sync <= '1;
            clk_sync <= '1;
            vld_sync <= '0;
            io_sync  <= '0;
        end else begin
            csb_sync <= {csb_sync[SYNC_STAGES-2:0], bus.qpi_csb};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.qpi_clk};
            vld_sync <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
            io_sync  <= {io_sync[SYNC_STAGES-2:0], bus.qpi_io_di};
        end
    end

    logic       csb_s, clk_s, sync_ok;
    logic [3:0] io_s;
    assign csb_s   = csb_sync[SYNC_STAGES-1];
    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign sync_ok = vld_sync[SYNC_STAGES-1];
    assign io_s    = io_sync[SYNC_STAGES-1];

    state_t     state_q, state_d;
    logic       csb_hi_q, clk_prev_q;
    logic       hi_held_q, hi_held_d, first_q, first_d;
    logic [3:0] nib_q, nib_d, io_do_q, io_do_d;
    logic [7:0] rx_data_q, rx_data_d, tx_byte_q, tx_byte_d, load_byte;
    logic       rx_valid_d, rx_first_d, rx_start_d, rx_stop_d, tx_ack_d;
    logic       rx_valid_q, rx_first_q, rx_start_q, rx_stop_q, tx_ack_q;
    logic       err_q, err_d, oe_q, oe_d, load;
    logic [1:0] cnt_q, cnt_d;
    logic       fall_e, rise_e;

    // csb_s high masks edges, so a csb rise coinciding with a clk edge wins
    assign fall_e    = !csb_s && clk_prev_q && !clk_s;
    assign rise_e    = !csb_s && !clk_prev_q && clk_s;
    assign load_byte = bus.tx_valid ? bus.tx_data : UNDERFLOW_BYTE;

    always_comb begin
        state_d    = state_q;
        hi_held_d  = hi_held_q;
        first_d    = first_q;
        nib_d      = nib_q;
        io_do_d    = io_do_q;
        rx_data_d  = rx_data_q;
        tx_byte_d  = tx_byte_q;
        err_d      = err_q;
        oe_d       = oe_q;
        cnt_d      = cnt_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        rx_start_d = 1'b0;
        rx_stop_d  = 1'b0;
        tx_ack_d   = 1'b0;
        load       = 1'b0;
        if (state_q == IDLE) begin
            // csb_hi_q only sets from a post-reset sample, so a frame cut by reset never restarts
            if (csb_hi_q && sync_ok && !csb_s) begin
                state_d    = RX;
                rx_start_d = 1'b1;
                hi_held_d  = 1'b0;
                first_d    = 1'b1;
                err_d      = 1'b0;
            end
        end else if (csb_s) begin
            state_d   = IDLE;
            rx_stop_d = 1'b1;
            oe_d      = 1'b0;
            io_do_d   = 4'h0;
            hi_held_d = 1'b0;
            if (state_q == RX && hi_held_q)
                err_d = 1'b1;
        end else begin
            case (state_q)
                RX: begin
                    if (fall_e) begin
                        if (bus.tx_mode) begin
                            hi_held_d = 1'b0;
                            cnt_d     = 2'd0;
                            if (DUMMY_CYCLES == 0) begin
                                load    = 1'b1;
                                state_d = TX;
                            end else begin
                                state_d = TURN;
                            end
                        end else begin
                            nib_d     = io_s;
                            hi_held_d = 1'b1;
                        end
                    end else if (rise_e && hi_held_q) begin
                        rx_data_d  = {nib_q, io_s};
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        hi_held_d  = 1'b0;
                    end
                end
                TURN: begin
                    if (rise_e) begin
                        if (cnt_q == 2'(LAST_DUMMY)) begin
                            load    = 1'b1;
                            state_d = TX;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                TX: begin
                    if (fall_e)
                        io_do_d = tx_byte_q[3:0];
                    else if (rise_e)
                        load = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        // every byte load consumes tx_data and presents its high nibble ahead of the next fall
        if (load) begin
            tx_ack_d  = 1'b1;
            oe_d      = 1'b1;
            tx_byte_d = load_byte;
            io_do_d   = load_byte[7:4];
            if (!bus.tx_valid)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            csb_hi_q   <= 1'b0;
            clk_prev_q <= 1'b1;
            hi_held_q  <= 1'b0;
            first_q    <= 1'b0;
            nib_q      <= 4'h0;
            io_do_q    <= 4'h0;
            rx_data_q  <= 8'h00;
            tx_byte_q  <= 8'h00;
            err_q      <= 1'b0;
            oe_q       <= 1'b0;
            cnt_q      <= 2'd0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            rx_start_q <= 1'b0;
            rx_stop_q  <= 1'b0;
            tx_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            csb_hi_q   <= sync_ok && csb_s;
            clk_prev_q <= clk_s;
            hi_held_q  <= hi_held_d;
            first_q    <= first_d;
            nib_q      <= nib_d;
            io_do_q    <= io_do_d;
            rx_data_q  <= rx_data_d;
            tx_byte_q  <= tx_byte_d;
            err_q      <= err_d;
            oe_q       <= oe_d;
            cnt_q      <= cnt_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            rx_start_q <= rx_start_d;
            rx_stop_q  <= rx_stop_d;
            tx_ack_q   <= tx_ack_d;
        end
    end

    assign bus.qpi_io_do = io_do_q;
    assign bus.qpi_io_oe = oe_q;
    assign bus.rx_start  = rx_start_q;
    assign bus.rx_stop   = rx_stop_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_first  = rx_first_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.tx_ack    = tx_ack_q;
    assign bus.err       = err_q;

`ifdef MLACCEL_QPI_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stat_q <= 16'h0000;
        else if (rx_start_d)
            stat_q <= 16'h0000;
        else if ((rx_valid_d || tx_ack_d) && stat_q != 16'hFFFF)
            stat_q <= stat_q + 16'h0001;
    end
    assign bus.stat_bytes = stat_q;
`endif
endmodule

// File: tb/tb_mlaccel_qpi_phy.sv
// tb/tb_mlaccel_qpi_phy.sv - directed table-driven bench for mlaccel_qpi_phy
module tb_mlaccel_qpi_phy;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mlaccel_qpi_phy_if bus();

    mlaccel_qpi_phy dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_start = 0, n_stop = 0, n_ack = 0;
    logic [8:0] rx_q[$];

    always @(negedge clock) begin
        if (bus.rx_valid) rx_q.push_back({bus.rx_first, bus.rx_data});
        if (bus.rx_start) n_start++;
        if (bus.rx_stop)  n_stop++;
        if (bus.tx_ack)   n_ack++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic host_start();
        bus.qpi_csb = 1'b0;
        cyc(8);
    endtask

    task automatic host_stop();
        bus.qpi_csb = 1'b1;
        cyc(2);
        bus.qpi_clk = 1'b1;
        cyc(8);
    endtask

    task automatic host_write(input logic [7:0] b);
        bus.qpi_io_di = b[7:4];
        cyc(4);
        bus.qpi_clk = 1'b0;
        cyc(4);
        bus.qpi_io_di = b[3:0];
        cyc(4);
        bus.qpi_clk = 1'b1;
        cyc(8);
    endtask

    task automatic host_turn(output logic oe_mid);
        cyc(4);
        bus.qpi_clk = 1'b0;
        cyc(6);
        oe_mid = bus.qpi_io_oe;
        cyc(2);
        bus.qpi_clk = 1'b1;
        cyc(8);
    endtask

    task automatic host_read(input bit rise_after, output logic [7:0] b, output logic oe_seen);
        b[7:4]  = bus.qpi_io_do;
        oe_seen = bus.qpi_io_oe;
        bus.qpi_clk = 1'b0;
        cyc(8);
        b[3:0] = bus.qpi_io_do;
        if (rise_after) begin
            bus.qpi_clk = 1'b1;
            cyc(8);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp_data, input logic exp_first);
        logic [8:0] e;
        if (rx_q.size() == 0) begin
            check({name, "_present"}, 32'd0, 32'd1);
        end else begin
            e = rx_q.pop_front();
            check({name, "_data"}, 32'(e[7:0]), 32'(exp_data));
            check({name, "_first"}, 32'(e[8]), 32'(exp_first));
        end
    endtask

    typedef struct {
        bit         new_frame;
        logic [7:0] din;
        logic [7:0] exp_data;
        bit         exp_first;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int s0, p0, a0;
        logic [7:0] r1, r2;
        logic oe_a, oe_b, oe_c;

        vecs[0] = '{1'b1, 8'h21, 8'h21, 1'b1};
        vecs[1] = '{1'b0, 8'h01, 8'h01, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 8'h08, 8'h08, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 8'hA5, 8'hA5, 1'b1};
        vecs[6] = '{1'b0, 8'h3C, 8'h3C, 1'b0};

        bus.qpi_csb = 1'b1; bus.qpi_clk = 1'b1; bus.qpi_io_di = 4'h0;
        bus.tx_mode = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        repeat (3) @(negedge clock);
        check("reset_oe", 32'(bus.qpi_io_oe), 32'd0);
        check("reset_do", 32'(bus.qpi_io_do), 32'd0);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_rx_start", 32'(bus.rx_start), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(6);

        // two frames from the table
        s0 = n_start; p0 = n_stop;
        host_start();
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].new_frame && i != 0) begin
                host_stop();
                host_start();
            end
            host_write(vecs[i].din);
            check($sformatf("t1_cnt%0d", i), 32'(rx_q.size()), 32'd1);
            pop_check($sformatf("t1_b%0d", i), vecs[i].exp_data, vecs[i].exp_first);
        end
        host_stop();
        check("t1_starts", 32'(n_start - s0), 32'd2);
        check("t1_stops", 32'(n_stop - p0), 32'd2);
        check("t1_err", 32'(bus.err), 32'd0);

        // read with one dummy pair
        rx_q.delete();
        a0 = n_ack;
        host_start();
        host_write(8'h23); host_write(8'h00); host_write(8'h00); host_write(8'h0A);
        check("t2_rx_cnt", 32'(rx_q.size()), 32'd4);
        bus.tx_mode = 1'b1; bus.tx_valid = 1'b1; bus.tx_data = 8'h5A;
        host_turn(oe_a);
        check("t2_dummy_oe", 32'(oe_a), 32'd0);
        bus.tx_data = 8'h00;
        host_read(1'b1, r1, oe_b);
        host_read(1'b0, r2, oe_c);
        check("t2_read0", 32'(r1), 32'h5A);
        check("t2_read1", 32'(r2), 32'h00);
        check("t2_oe_on", 32'(oe_b & oe_c), 32'd1);
        check("t2_acks", 32'(n_ack - a0), 32'd2);
        bus.tx_valid = 1'b0;
        bus.qpi_csb = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("t2_oe_off", 32'(bus.qpi_io_oe), 32'd0);
        cyc(2);
        bus.qpi_clk = 1'b1;
        cyc(8);
        check("t2_err", 32'(bus.err), 32'd0);
        bus.tx_mode = 1'b0;

        // underflow read
        rx_q.delete();
        a0 = n_ack;
        host_start();
        host_write(8'h0B);
        bus.tx_mode = 1'b1; bus.tx_valid = 1'b0; bus.tx_data = 8'h12;
        host_turn(oe_a);
        host_read(1'b0, r1, oe_b);
        check("t3_read", 32'(r1), 32'hFF);
        check("t3_err", 32'(bus.err), 32'd1);
        check("t3_ack", 32'(n_ack - a0), 32'd1);
        host_stop();
        check("t3_err_held", 32'(bus.err), 32'd1);
        bus.tx_mode = 1'b0;

        // partial byte at csb rise
        rx_q.delete();
        p0 = n_stop;
        host_start();
        check("t4_err_cleared", 32'(bus.err), 32'd0);
        host_write(8'h11);
        bus.qpi_io_di = 4'h7;
        cyc(4);
        bus.qpi_clk = 1'b0;
        cyc(8);
        host_stop();
        check("t4_rx_cnt", 32'(rx_q.size()), 32'd1);
        pop_check("t4_b0", 8'h11, 1'b1);
        check("t4_stop", 32'(n_stop - p0), 32'd1);
        check("t4_err", 32'(bus.err), 32'd1);
        host_start();
        check("t4_err_next", 32'(bus.err), 32'd0);
        host_write(8'h5C);
        host_stop();
        pop_check("t4_next", 8'h5C, 1'b1);

        // reset mid-frame
        rx_q.delete();
        host_start();
        host_write(8'h01); host_write(8'h02);
        bus.qpi_io_di = 4'h3;
        cyc(4);
        bus.qpi_clk = 1'b0;
        cyc(4);
        reset = 1'b1;
        @(negedge clock);
        check("t5_rst_oe", 32'(bus.qpi_io_oe), 32'd0);
        check("t5_rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("t5_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        cyc(2);
        reset = 1'b0;
        rx_q.delete();
        s0 = n_start;
        bus.qpi_io_di = 4'h4;
        cyc(4);
        bus.qpi_clk = 1'b1;
        cyc(8);
        host_write(8'hAA);
        check("t5_no_rx", 32'(rx_q.size()), 32'd0);
        check("t5_no_start", 32'(n_start - s0), 32'd0);
        host_stop();
        host_start();
        check("t5_start", 32'(n_start - s0), 32'd1);
        host_write(8'h33); host_write(8'h44);
        host_stop();
        check("t5_rx_cnt", 32'(rx_q.size()), 32'd2);
        pop_check("t5_b0", 8'h33, 1'b1);
        pop_check("t5_b1", 8'h44, 1'b0);

`ifdef MLACCEL_QPI_STATS_EN
        rx_q.delete();
        host_start();
        host_write(8'h0B); host_write(8'h01); host_write(8'h02);
        bus.tx_mode = 1'b1; bus.tx_valid = 1'b1; bus.tx_data = 8'h77;
        host_turn(oe_a);
        host_read(1'b1, r1, oe_b);
        host_read(1'b1, r1, oe_b);
        host_read(1'b1, r1, oe_b);
        host_read(1'b0, r1, oe_b);
        host_stop();
        bus.tx_mode = 1'b0; bus.tx_valid = 1'b0;
        check("t6_stats", 32'(bus.stat_bytes), 32'd7);
        host_start();
        check("t6_stats_clr", 32'(bus.stat_bytes), 32'd0);
        host_stop();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
